// File: rtl/melee_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : melee_pkg
//  Description : Shared types and default constants for the melee swing
//                sequencer (state encoding, timing defaults, class code).
//  Revision    : 1.0 - initial release
// ============================================================================
package melee_pkg;

  // Swing sequencer phases
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXTEND   = 2'd1,
    RETRACT  = 2'd2,
    COOLDOWN = 2'd3
  } swing_state_t;

  // Default timing for a swing
  localparam int DEF_SWING_FRAMES    = 8;
  localparam int DEF_STEP_PX         = 4;
  localparam int DEF_COOLDOWN_FRAMES = 12;

  // Character class code that is allowed to swing
  localparam logic [1:0] CLASS_MELEE = 2'd1;

  // Width of a counter that must hold values up to max(a, b)
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rise_edge.sv
`default_nettype none
// ============================================================================
//  Module      : rise_edge
//  Description : Single-flop rising-edge detector. Output is high for one
//                clock when the input goes from 0 to 1. Asynchronous
//                active-low reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module rise_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  // Remember the previous sample so a 0->1 transition is seen once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule
`default_nettype wire

// File: rtl/melee_swing_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : melee_swing_ctrl
//  Description : Melee swing sequencer. Turns left-button presses into a
//                frame-stepped extend/retract swing followed by a cooldown,
//                drives the draw stage's attack enable and weapon offset, and
//                reduces per-pixel hits to one damage pulse per swing.
//  Options     : MELEE_INPUT_BUFFER_EN - buffer one press made during
//                RETRACT/COOLDOWN and start the next swing directly when the
//                cooldown ends.
//  Revision    : 1.0 - initial release
// ============================================================================
module melee_swing_ctrl
  import melee_pkg::*;
#(
  parameter int SWING_FRAMES    = DEF_SWING_FRAMES,
  parameter int STEP_PX         = DEF_STEP_PX,
  parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        mouse_left,
  input  logic [1:0]  game_active,
  input  logic [1:0]  char_class,
  input  logic        alive,
  input  logic        melee_hit,
  output logic        swing_active,
  output logic [11:0] anim_x_offset,
  output logic        dmg_pulse,
  output logic        busy
);

  localparam int          CNT_W     = cnt_width(SWING_FRAMES, COOLDOWN_FRAMES);
  localparam logic [CNT_W-1:0] SWING_LAST = CNT_W'(SWING_FRAMES - 1);
  localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(COOLDOWN_FRAMES - 1);
  localparam logic [11:0] STEP      = 12'(STEP_PX);

  // Parameter sanity: the fully extended offset must fit in 12 bits
  if (SWING_FRAMES * STEP_PX >= 4096) begin : g_offset_range_err
    $error("melee_swing_ctrl: SWING_FRAMES*STEP_PX must be below 4096");
  end
  if (SWING_FRAMES < 1 || COOLDOWN_FRAMES < 1 || STEP_PX < 1) begin : g_param_min_err
    $error("melee_swing_ctrl: frame counts and step must be at least 1");
  end

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic tick_w;
  logic press_w;
  logic en_w;

  rise_edge u_vblnk_edge (
    .clk    (clk),
    .rst    (rst),
    .d_i    (vblnk),
    .rise_o (tick_w)
  );

  rise_edge u_press_edge (
    .clk    (clk),
    .rst    (rst),
    .d_i    (mouse_left),
    .rise_o (press_w)
  );

  assign en_w = (game_active != 2'd0) && (char_class == CLASS_MELEE) && alive;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  swing_state_t     state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [11:0]      offset_q,   offset_d;
  logic             hit_done_q, hit_done_d;
  logic             dmg_q,      dmg_d;
  logic             swing_q,    swing_d;
  logic             busy_q,     busy_d;
`ifdef MELEE_INPUT_BUFFER_EN
  logic             pending_q,  pending_d;
`endif

  // Register all state and the registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      offset_q   <= '0;
      hit_done_q <= 1'b0;
      dmg_q      <= 1'b0;
      swing_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef MELEE_INPUT_BUFFER_EN
      pending_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      offset_q   <= offset_d;
      hit_done_q <= hit_done_d;
      dmg_q      <= dmg_d;
      swing_q    <= swing_d;
      busy_q     <= busy_d;
`ifdef MELEE_INPUT_BUFFER_EN
      pending_q  <= pending_d;
`endif
    end
  end

  // Next-state, offset stepping, hit reduction and abort handling
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    offset_d   = offset_q;
    hit_done_d = hit_done_q;
    dmg_d      = 1'b0;
`ifdef MELEE_INPUT_BUFFER_EN
    pending_d  = pending_q;
`endif

    // One damage pulse per swing; cooldown still listens so hits that are
    // late through the draw pipeline are not lost.
    if (state_q != IDLE && melee_hit && !hit_done_q) begin
      dmg_d      = 1'b1;
      hit_done_d = 1'b1;
    end

`ifdef MELEE_INPUT_BUFFER_EN
    if ((state_q == RETRACT || state_q == COOLDOWN) && press_w) begin
      pending_d = 1'b1;
    end
`endif

    case (state_q)
      IDLE: begin
        // A tick in the same cycle as the press is deliberately not counted
        if (press_w && en_w) begin
          state_d    = EXTEND;
          cnt_d      = '0;
          offset_d   = '0;
          hit_done_d = 1'b0;
        end
      end

      EXTEND: begin
        if (tick_w) begin
          offset_d = offset_q + STEP;
          if (cnt_q == SWING_LAST) begin
            state_d = RETRACT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      RETRACT: begin
        if (tick_w) begin
          offset_d = offset_q - STEP;
          if (offset_q == STEP) begin
            state_d = COOLDOWN;
            cnt_d   = '0;
          end
        end
      end

      COOLDOWN: begin
        if (tick_w) begin
          if (cnt_q == COOL_LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
`ifdef MELEE_INPUT_BUFFER_EN
            // Chain straight into the buffered swing, no IDLE cycle
            if ((pending_q || press_w) && en_w) begin
              state_d    = EXTEND;
              offset_d   = '0;
              hit_done_d = 1'b0;
              pending_d  = 1'b0;
            end
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Losing the enable aborts the swing; this overrides any tick or hit
    if (state_q != IDLE && !en_w) begin
      state_d  = IDLE;
      cnt_d    = '0;
      offset_d = '0;
      dmg_d    = 1'b0;
`ifdef MELEE_INPUT_BUFFER_EN
      pending_d = 1'b0;
`endif
    end

    swing_d = (state_d == EXTEND) || (state_d == RETRACT);
    busy_d  = (state_d != IDLE);
  end

  assign swing_active  = swing_q;
  assign anim_x_offset = offset_q;
  assign dmg_pulse     = dmg_q;
  assign busy          = busy_q;

endmodule
`default_nettype wire
